// File: rtl/int_src_ctrl.sv
// -----------------------------------------------------------------------------
// int_src_ctrl
//   Interrupt source controller driving the CPU's external INT line.
//   Synchronizes up to N asynchronous request lines, latches rising edges as
//   pending, applies a software mask and fixed lowest-index-first priority,
//   and issues one PULSE-cycle INT pulse per accepted request. Further
//   requests are held off until the CPU's eret retires the in-service one.
//
// Ports
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   irq_in   in   [N-1:0] raw request lines, asynchronous, rising-edge sensitive
//   eret     in   one-cycle return-from-exception strobe
//   we       in   register write strobe
//   addr     in   [1:0] register select (0 MASK, 1 PENDING, 2 STATUS, 3 COUNT)
//   wdata    in   [31:0] write data
//   rdata    out  [31:0] read data, combinational from addr
//   INT      out  registered interrupt request to the CPU
//   int_id   out  [3:0] registered index of the in-service source
//   busy     out  registered, high while in ASSERT or SERVICE
// -----------------------------------------------------------------------------
module int_src_ctrl #(
  parameter int N     = 4,
  parameter int PULSE = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] irq_in,
  input  logic         eret,
  input  logic         we,
  input  logic [1:0]   addr,
  input  logic [31:0]  wdata,
  output logic [31:0]  rdata,
  output logic         INT,
  output logic [3:0]   int_id,
  output logic         busy
);

  // The pulse counter only ever holds PULSE-1 down to 0.
  localparam int CW = (PULSE > 1) ? $clog2(PULSE) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t         state;
  logic [CW-1:0]  pulse_cnt;

  logic [N-1:0]   sync1, sync2, sync_prev;
  logic [N-1:0]   edge_det;
  logic [N-1:0]   pending;
  logic [N-1:0]   mask_q;
  logic [31:0]    count;

  logic [N-1:0]   req;
  logic [N-1:0]   take;
  logic [N-1:0]   w1c;
  logic [3:0]     winner;
  logic           start;

  // Upper write-data bits beyond the N request lines have no destination.
  logic           unused_wdata;
  assign unused_wdata = ^wdata[31:N];

  // ---------------------------------------------------------------------------
  // Input synchronizers and rising-edge detect. sync_prev is the previous
  // sample of sync2, so an edge is seen exactly once per low-to-high transition.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source, making the three-stage chain order-safe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1     <= '0;
      sync2     <= '0;
      sync_prev <= '0;
    end else begin
      sync1     <= irq_in;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign edge_det = sync2 & ~sync_prev;

  // ---------------------------------------------------------------------------
  // Priority select: lowest enabled pending index wins. Iterating from the top
  // down lets the last match (the lowest index) overwrite earlier ones.
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the loop; without
  // it, the no-request case would hold the old value and infer a latch.
  always_comb begin
    winner = '0;
    take   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        winner  = 4'(i);
        take    = '0;
        take[i] = 1'b1;
      end
    end
    if (state != IDLE) take = '0;
  end

  assign req   = pending & mask_q;
  assign start = (state == IDLE) && (|req);
  assign w1c   = (we && addr == 2'd1) ? wdata[N-1:0] : '0;

  // ---------------------------------------------------------------------------
  // Pending, mask and retired-interrupt count. A fresh edge overrides both a
  // same-cycle W1C and the capture clear, so no new request is ever lost.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
      mask_q  <= '0;
      count   <= '0;
    end else begin
      pending <= (pending & ~(w1c | take)) | edge_det;
      if (we && addr == 2'd0) mask_q <= wdata[N-1:0];
      if (state == SERVICE && eret) count <= count + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs. int_id is captured at acceptance, so
  // later MASK writes cannot disturb the in-service interrupt.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      pulse_cnt <= '0;
      INT       <= 1'b0;
      int_id    <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= ASSERT;
            int_id    <= winner;
            pulse_cnt <= CW'(PULSE - 1);
            INT       <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ASSERT: begin
          if (pulse_cnt == '0) begin
            state <= SERVICE;
            INT   <= 1'b0;
          end else begin
            pulse_cnt <= pulse_cnt - CW'(1);
          end
        end
        SERVICE: begin
          // Returning to IDLE costs one cycle, guaranteeing a low gap on INT.
          if (eret) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          INT   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Register read port.
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata = '0;
    case (addr)
      2'd0: rdata = 32'(mask_q);
      2'd1: rdata = 32'(pending);
      2'd2: rdata = {23'd0, busy, 4'd0, int_id};
      2'd3: rdata = count;
      default: rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_int_src_ctrl.sv
// -----------------------------------------------------------------------------
// tb_int_src_ctrl
//   Directed bench for int_src_ctrl (N=4, PULSE=2). Inputs are driven and
//   outputs sampled on the falling clock edge; expected values are written
//   out by hand for each step.
// -----------------------------------------------------------------------------
module tb_int_src_ctrl;

  localparam int N = 4;

  logic         clk;
  logic         reset_n;
  logic [N-1:0] irq_in;
  logic         eret;
  logic         we;
  logic [1:0]   addr;
  logic [31:0]  wdata;
  logic [31:0]  rdata;
  logic         INT;
  logic [3:0]   int_id;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  int_src_ctrl #(.N(N), .PULSE(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .irq_in  (irq_in),
    .eret    (eret),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .INT     (INT),
    .int_id  (int_id),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against any stall in the directed sequence.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one full cycle, ending on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    tick();
    we    = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  task automatic do_eret();
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  // Raise the given lines for one cycle; returns just after edge E0.
  task automatic pulse_irq(input logic [N-1:0] lines);
    irq_in = lines;
    tick();
    irq_in = '0;
  endtask

  initial begin
    reset_n = 1'b0;
    irq_in  = '0;
    eret    = 1'b0;
    we      = 1'b0;
    addr    = 2'd0;
    wdata   = '0;
    @(negedge clk);
    @(negedge clk);

    // ---- reset state ----
    check("rst_int",    32'(INT),    32'd0);
    check("rst_int_id", 32'(int_id), 32'd0);
    check("rst_busy",   32'(busy),   32'd0);
    reset_n = 1'b1;
    chk_reg("rst_mask",    2'd0, 32'd0);
    chk_reg("rst_pending", 2'd1, 32'd0);
    chk_reg("rst_status",  2'd2, 32'd0);
    chk_reg("rst_count",   2'd3, 32'd0);

    // ---- single request on line 0 ----
    wr(2'd0, 32'h1);
    chk_reg("s1_mask", 2'd0, 32'h1);
    pulse_irq(4'b0001);                       // E0
    check("s1_int_e0", 32'(INT), 32'd0);
    tick();                                   // E1
    check("s1_int_e1", 32'(INT), 32'd0);
    tick();                                   // E2
    check("s1_int_e2", 32'(INT), 32'd0);
    chk_reg("s1_pend_e2", 2'd1, 32'h1);
    tick();                                   // E3
    check("s1_int_e3",  32'(INT),    32'd1);
    check("s1_id_e3",   32'(int_id), 32'd0);
    check("s1_busy_e3", 32'(busy),   32'd1);
    chk_reg("s1_pend_e3", 2'd1, 32'h0);
    tick();                                   // E4
    check("s1_int_e4", 32'(INT), 32'd1);
    tick();                                   // E5
    check("s1_int_e5", 32'(INT), 32'd0);
    chk_reg("s1_status_svc", 2'd2, 32'h100);
    tick();
    check("s1_int_svc", 32'(INT), 32'd0);
    do_eret();
    check("s1_busy_done", 32'(busy), 32'd0);
    chk_reg("s1_count", 2'd3, 32'd1);

    // ---- priority: lines 2 and 1 together ----
    wr(2'd0, 32'hF);
    pulse_irq(4'b0110);
    tick();
    tick();
    chk_reg("s2_pend_both", 2'd1, 32'h6);
    tick();
    check("s2_int_first", 32'(INT),    32'd1);
    check("s2_id_first",  32'(int_id), 32'd1);
    chk_reg("s2_pend_left", 2'd1, 32'h4);
    tick();
    tick();
    check("s2_int_low", 32'(INT), 32'd0);
    do_eret();
    check("s2_int_gap",  32'(INT),  32'd0);
    check("s2_busy_gap", 32'(busy), 32'd0);
    tick();
    check("s2_int_second", 32'(INT),    32'd1);
    check("s2_id_second",  32'(int_id), 32'd2);
    chk_reg("s2_status", 2'd2, 32'h102);
    tick();
    tick();
    do_eret();
    chk_reg("s2_count", 2'd3, 32'd3);

    // ---- masking: line 3 pending while masked ----
    wr(2'd0, 32'h0);
    pulse_irq(4'b1000);
    tick();
    tick();
    tick();
    tick();
    check("s3_int_masked", 32'(INT), 32'd0);
    chk_reg("s3_pend_kept", 2'd1, 32'h8);
    wr(2'd0, 32'h8);
    check("s3_int_wr_edge", 32'(INT), 32'd0);
    tick();
    check("s3_int_unmask", 32'(INT),    32'd1);
    check("s3_id_unmask",  32'(int_id), 32'd3);
    tick();
    tick();
    check("s3_int_svc", 32'(INT), 32'd0);

    // ---- busy hold-off: line 0 edge during SERVICE ----
    wr(2'd0, 32'h1);                          // mask change while in service
    check("s4_id_held", 32'(int_id), 32'd3);
    pulse_irq(4'b0001);
    tick();
    tick();
    tick();
    tick();
    check("s4_int_held",  32'(INT),  32'd0);
    check("s4_busy_held", 32'(busy), 32'd1);
    chk_reg("s4_pend_wait", 2'd1, 32'h1);
    do_eret();
    check("s4_int_gap", 32'(INT), 32'd0);
    tick();
    check("s4_int_fire", 32'(INT),    32'd1);
    check("s4_id_fire",  32'(int_id), 32'd0);
    tick();
    tick();
    do_eret();
    chk_reg("s4_count", 2'd3, 32'd5);
    do_eret();                                // eret in IDLE is ignored
    chk_reg("s4_count_idle_eret", 2'd3, 32'd5);
    check("s4_int_idle", 32'(INT), 32'd0);

    // ---- W1C ----
    wr(2'd0, 32'h0);
    pulse_irq(4'b0010);
    tick();
    tick();
    chk_reg("s5_pend_set", 2'd1, 32'h2);
    wr(2'd1, 32'h2);
    chk_reg("s5_pend_clr", 2'd1, 32'h0);
    pulse_irq(4'b0010);                       // E0
    tick();                                   // E1; edge lands at E2
    wr(2'd1, 32'h2);                          // W1C on E2, same edge as set
    chk_reg("s5_set_wins", 2'd1, 32'h2);

    // ---- reset mid-pulse ----
    wr(2'd0, 32'h2);
    tick();
    check("s6_int_pre", 32'(INT), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("s6_int_async",  32'(INT),    32'd0);
    check("s6_busy_async", 32'(busy),   32'd0);
    check("s6_id_async",   32'(int_id), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    chk_reg("s6_mask",    2'd0, 32'd0);
    chk_reg("s6_pending", 2'd1, 32'd0);
    chk_reg("s6_status",  2'd2, 32'd0);
    chk_reg("s6_count",   2'd3, 32'd0);
    for (int i = 0; i < 6; i++) tick();
    check("s6_int_quiet",  32'(INT),  32'd0);
    check("s6_busy_quiet", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/int_src_ctrl.md
# int_src_ctrl

Interrupt source controller that drives the CPU's external `INT` line. It collects up to `N` asynchronous interrupt request lines, latches rising edges as pending, applies a software mask and fixed priority, and issues one `INT` pulse per accepted request. It then holds off further requests until the CPU's `eret` retires the in-service interrupt. The block sits beside the CPU core on the same clock and exposes a small register port so the handler at 0x00000004 can read which source fired.

## Interface
- `N`, default 4: number of request lines, 1..16.
- `PULSE`, default 2: cycles `INT` is held high per request, ≥1.
- `clk`  in  1: system clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `irq_in`  in  N: raw request lines, asynchronous to `clk`, rising-edge sensitive.
- `eret`  in  1: CPU return-from-exception strobe, one cycle, synchronous.
- `we`  in  1: register write strobe.
- `addr`  in  2: register select.
- `wdata`  in  32: write data.
- `rdata`  out  32: read data, combinational from `addr`.
- `INT`  out  1: interrupt request to CPU, registered.
- `int_id`  out  4: index of in-service source, registered.
- `busy`  out  1: high in ASSERT or SERVICE.

## Operation
- Input path per line: 2-flop synchronizer, then rising-edge detect (sync2 high, previous sample low) sets `pending[i]`.
- Registers:
  - addr 0 MASK: RW, bits N-1:0, 1 = enabled, reset 0.
  - addr 1 PENDING: read gives pending; write-1-to-clear.
  - addr 2 STATUS: {busy in bit 8, int_id in bits 3:0}.
  - addr 3 COUNT: 32-bit count of retired interrupts, wraps 0xFFFFFFFF→0.
  - Unused read bits return 0.
- Priority: lowest index among `pending & MASK` wins.
- FSM:
  - IDLE: if `pending & MASK` ≠ 0 → ASSERT. On that edge: `int_id` ← winner, `pending[winner]` ← 0, pulse counter ← PULSE-1, `INT` ← 1.
  - ASSERT: `INT`=1. Counter decrements each cycle; at 0 → SERVICE, `INT` ← 0.
  - SERVICE: `INT`=0. On `eret` → IDLE and COUNT+1.
  - `eret` in IDLE or ASSERT is ignored.
- Edges arriving while busy set pending normally and are serviced later; repeat edges on an already-pending line merge.
- MASK writes during ASSERT/SERVICE do not affect the in-service interrupt. Masked pending bits are retained and fire once unmasked.
- Same-edge W1C and edge-set on one bit: set wins. Same-edge W1C and ASSERT capture: winner is taken and its bit stays cleared.

## Timing
- Reset values (asynchronous, immediate on `reset_n` low): `INT`=0, `int_id`=0, `busy`=0, MASK=0, PENDING=0, COUNT=0, synchronizers=0, FSM=IDLE.
- Reset mid-ASSERT drops `INT` asynchronously. No interrupt is remembered after reset.
- Latency: with the line unmasked and FSM in IDLE, `irq_in` rising before clk edge E0 gives sync1 at E0, sync2 at E1, pending at E2, and `INT` high from E3.
- `INT` high for exactly PULSE cycles, giving the CPU edge-latch a clean rising edge.
- IDLE lasts at least 1 cycle after `eret`, so back-to-back `INT` pulses are separated by ≥1 low cycle plus the SERVICE time.
- Register writes take effect at the clock edge of `we`. `rdata` reflects state after the previous edge.

## Test plan
- Single request: MASK=0x1, pulse `irq_in[0]` → `INT` high 3 edges later for 2 cycles, `int_id`=0, PENDING=0. `eret` → busy=0, COUNT=1.
- Priority: raise `irq_in[2]` and `irq_in[1]` same cycle, MASK=0xF → first `int_id`=1. After `eret`, second `INT` with `int_id`=2. COUNT=2.
- Masking: MASK=0, edge on line 3 → no `INT`, PENDING=0x8. Write MASK=0x8 → `INT` next edge, `int_id`=3.
- Busy hold-off: edge on line 0 during SERVICE → `INT` stays 0 until `eret`, then fires with `int_id`=0. `eret` in IDLE leaves COUNT unchanged.
- W1C: pending=0x2, write PENDING 0x2 with MASK=0 → PENDING=0. Same-edge new edge on line 1 with W1C → PENDING=0x2.
- Reset mid-pulse: assert `reset_n`=0 during ASSERT → `INT`=0 immediately. After release, all registers are 0 and no `INT` occurs.
